booth_mult_arbiter: RTL and testbench

// Shares one booth_multiplier instance between NUM_REQ requesters. Picks requesters round-robin,

---
 rtl/booth_arb_pkg.sv | 24 ++
 rtl/booth_multiplier.sv | 73 +++++++
 rtl/rr_arbiter.sv | 31 +++
 rtl/booth_mult_arbiter.sv | 151 +++++++++++++++
 tb/tb_booth_mult_arbiter.sv | 489 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/booth_arb_pkg.sv
// Shared types and sizing helpers for the booth multiplier arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package booth_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      ABORT,
      RESPOND
   } state_t;

   // Width of a requester index; never below one bit.
   function automatic int id_width(input int num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

   // Width of a watchdog that must be able to hold timeout-1.
   function automatic int wd_width(input int timeout);
      return (timeout > 2) ? $clog2(timeout) : 1;
   endfunction

endpackage

// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth signed multiplier, one recoded bit per cycle.
// Latency: start sampled, then N step cycles; o_done pulses with the product valid.
// Backpressure: none; a new start restarts the operation.
module booth_multiplier #(
   parameter int N = 4
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_start,
   input  logic [N-1:0]   i_multiplicand,
   input  logic [N-1:0]   i_multiplier,
   output logic [2*N-1:0] o_product,
   output logic           o_done
);

   localparam int CW = $clog2(N + 1);

   logic [2*N-1:0] r_acc;
   logic [2*N-1:0] r_mcand;
   logic [N-1:0]   r_mplier;
   logic           r_q1;
   logic [CW-1:0]  r_cnt;
   logic           r_busy;
   logic           r_done;
   logic [2*N-1:0] w_acc_nxt;

   // Booth recoding of the current multiplier bit pair selects add, subtract or keep.
   always_comb begin
      w_acc_nxt = r_acc;
      case ({r_mplier[0], r_q1})
         2'b01:   w_acc_nxt = r_acc + r_mcand;
         2'b10:   w_acc_nxt = r_acc - r_mcand;
         default: w_acc_nxt = r_acc;
      endcase
   end

   // Load on start, then step N times with the multiplicand shifted up each step.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_q1     <= 1'b0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (i_start) begin
            r_acc    <= '0;
            r_mcand  <= {{N{i_multiplicand[N-1]}}, i_multiplicand};
            r_mplier <= i_multiplier;
            r_q1     <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
         end else if (r_busy) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= {r_mcand[2*N-2:0], 1'b0};
            r_mplier <= {r_mplier[N-1], r_mplier[N-1:1]};
            r_q1     <= r_mplier[0];
            r_cnt    <= r_cnt + CW'(1);
            if (r_cnt == CW'(N - 1)) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end
         end
      end
   end

   assign o_product = r_acc;
   assign o_done    = r_done;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin priority pick: first set request at or above i_ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is taken.
module rr_arbiter
   import booth_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = id_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [ID_W-1:0]    i_ptr,
   output logic [NUM_REQ-1:0] o_grant_onehot,
   output logic [ID_W-1:0]    o_grant_idx,
   output logic               o_any_grant
);

   // Walk the requests starting at the pointer; the first hit wins.
   always_comb begin
      o_grant_onehot = '0;
      o_grant_idx    = '0;
      o_any_grant    = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!o_any_grant && i_req[(int'(i_ptr) + k) % NUM_REQ]) begin
            o_any_grant                                  = 1'b1;
            o_grant_onehot[(int'(i_ptr) + k) % NUM_REQ] = 1'b1;
            o_grant_idx                                  = ID_W'((int'(i_ptr) + k) % NUM_REQ);
         end
      end
   end

endmodule

// File: rtl/booth_mult_arbiter.sv
// Shares one Booth multiplier among NUM_REQ requesters, round-robin, one job in flight.
// Latency: grant to o_resp_valid is 2 + multiplier cycles; watchdog aborts after TIMEOUT.
// Backpressure: response held until i_resp_ready; no grants while a job or response is pending.
module booth_mult_arbiter
   import booth_arb_pkg::*;
#(
   parameter  int N       = 4,
   parameter  int NUM_REQ = 4,
   parameter  int TIMEOUT = 64,
   localparam int ID_W    = id_width(NUM_REQ)
) (
   input  logic                 i_clock,
   input  logic                 i_reset_n,
   input  logic [NUM_REQ-1:0]   i_req_valid,
   output logic [NUM_REQ-1:0]   o_req_ready,
   input  logic [NUM_REQ*N-1:0] i_req_multiplicand,
   input  logic [NUM_REQ*N-1:0] i_req_multiplier,
   output logic                 o_resp_valid,
   input  logic                 i_resp_ready,
   output logic [ID_W-1:0]      o_resp_id,
   output logic [2*N-1:0]       o_resp_product,
   output logic                 o_resp_error,
   output logic                 o_busy,
   output logic                 o_mult_start,
   output logic [N-1:0]         o_mult_multiplicand,
   output logic [N-1:0]         o_mult_multiplier,
   output logic                 o_mult_abort,
   input  logic [2*N-1:0]       i_mult_product,
   input  logic                 i_mult_done
);

   localparam int WD_W = wd_width(TIMEOUT);

   state_t         r_state;
   logic [ID_W-1:0] r_rr_ptr;
   logic [WD_W-1:0] r_wd;
   logic            r_mult_start;
   logic            r_mult_abort;
   logic [N-1:0]    r_mcand;
   logic [N-1:0]    r_mplier;
   logic [ID_W-1:0] r_resp_id;
   logic [2*N-1:0]  r_resp_product;
   logic            r_resp_error;
   logic            r_resp_valid;

   logic [NUM_REQ-1:0] w_grant;
   logic [ID_W-1:0]    w_grant_idx;
   logic               w_any_grant;
   logic [N-1:0]       w_sel_mcand;
   logic [N-1:0]       w_sel_mplier;
   logic [ID_W-1:0]    w_next_ptr;
   logic [WD_W-1:0]    w_wd_nxt;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .i_req          (i_req_valid),
      .i_ptr          (r_rr_ptr),
      .o_grant_onehot (w_grant),
      .o_grant_idx    (w_grant_idx),
      .o_any_grant    (w_any_grant)
   );

   // Operand mux driven by the one-hot grant.
   always_comb begin
      w_sel_mcand  = '0;
      w_sel_mplier = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant[i]) begin
            w_sel_mcand  = i_req_multiplicand[i*N +: N];
            w_sel_mplier = i_req_multiplier[i*N +: N];
         end
      end
   end

   assign w_next_ptr = (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + ID_W'(1);
   assign w_wd_nxt   = r_wd + WD_W'(1);

   // Request/issue/wait/respond sequencer with watchdog and registered strobes.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state        <= IDLE;
         r_rr_ptr       <= '0;
         r_wd           <= '0;
         r_mult_start   <= 1'b0;
         r_mult_abort   <= 1'b0;
         r_mcand        <= '0;
         r_mplier       <= '0;
         r_resp_id      <= '0;
         r_resp_product <= '0;
         r_resp_error   <= 1'b0;
         r_resp_valid   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any_grant) begin
                  r_mcand      <= w_sel_mcand;
                  r_mplier     <= w_sel_mplier;
                  r_resp_id    <= w_grant_idx;
                  r_rr_ptr     <= w_next_ptr;
                  r_mult_start <= 1'b1;
                  r_state      <= ISSUE;
               end
            end
            ISSUE: begin
               r_mult_start <= 1'b0;
               r_wd         <= '0;
               r_state      <= WAIT;
            end
            WAIT: begin
               r_wd <= w_wd_nxt;
               // A done arriving on the timeout cycle still counts as success.
               if (i_mult_done) begin
                  r_resp_product <= i_mult_product;
                  r_resp_error   <= 1'b0;
                  r_resp_valid   <= 1'b1;
                  r_state        <= RESPOND;
               end else if (w_wd_nxt == WD_W'(TIMEOUT - 1)) begin
                  r_mult_abort <= 1'b1;
                  r_state      <= ABORT;
               end
            end
            ABORT: begin
               r_mult_abort   <= 1'b0;
               r_resp_product <= '0;
               r_resp_error   <= 1'b1;
               r_resp_valid   <= 1'b1;
               r_state        <= RESPOND;
            end
            RESPOND: begin
               if (i_resp_ready && r_resp_valid) begin
                  r_resp_valid <= 1'b0;
                  r_state      <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Accept pulse only while idle; held low during reset so every output reads zero.
   assign o_req_ready         = (r_state == IDLE && i_reset_n) ? w_grant : '0;
   assign o_busy              = (r_state != IDLE);
   assign o_mult_start        = r_mult_start;
   assign o_mult_abort        = r_mult_abort;
   assign o_mult_multiplicand = r_mcand;
   assign o_mult_multiplier   = r_mplier;
   assign o_resp_valid        = r_resp_valid;
   assign o_resp_id           = r_resp_id;
   assign o_resp_product      = r_resp_product;
   assign o_resp_error        = r_resp_error;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Testbench for booth_mult_arbiter driving a real booth_multiplier, with a stub path for watchdog cases.
// Latency: n/a.
// Backpressure: consumer ready is driven by each scenario.
module tb_booth_mult_arbiter;

   localparam int TO = 64;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [15:0] req_mcand;
   logic [15:0] req_mplier;
   logic        resp_valid;
   logic        resp_ready;
   logic [1:0]  resp_id;
   logic [7:0]  resp_product;
   logic        resp_error;
   logic        busy;
   logic        mult_start;
   logic [3:0]  mult_mcand;
   logic [3:0]  mult_mplier;
   logic        mult_abort;
   logic [7:0]  real_prod;
   logic        real_done;
   logic        stub_mode;
   logic        stub_done;
   logic [7:0]  stub_prod;
   logic [7:0]  mult_prod_mux;
   logic        mult_done_mux;
   logic        mult_rst_n;

   int checks = 0;
   int errors = 0;
   int model_ptr = 0;

   always #5 clk = ~clk;

   assign mult_rst_n    = reset_n & ~mult_abort;
   assign mult_prod_mux = stub_mode ? stub_prod : real_prod;
   assign mult_done_mux = stub_mode ? stub_done : real_done;

   booth_multiplier #(.N(4)) u_mult (
      .i_clk          (clk),
      .i_rst_n        (mult_rst_n),
      .i_start        (mult_start),
      .i_multiplicand (mult_mcand),
      .i_multiplier   (mult_mplier),
      .o_product      (real_prod),
      .o_done         (real_done)
   );

   booth_mult_arbiter #(.N(4), .NUM_REQ(4), .TIMEOUT(TO)) dut (
      .i_clock             (clk),
      .i_reset_n           (reset_n),
      .i_req_valid         (req_valid),
      .o_req_ready         (req_ready),
      .i_req_multiplicand  (req_mcand),
      .i_req_multiplier    (req_mplier),
      .o_resp_valid        (resp_valid),
      .i_resp_ready        (resp_ready),
      .o_resp_id           (resp_id),
      .o_resp_product      (resp_product),
      .o_resp_error        (resp_error),
      .o_busy              (busy),
      .o_mult_start        (mult_start),
      .o_mult_multiplicand (mult_mcand),
      .o_mult_multiplier   (mult_mplier),
      .o_mult_abort        (mult_abort),
      .i_mult_product      (mult_prod_mux),
      .i_mult_done         (mult_done_mux)
   );

   // ---------------- reference model ----------------
   function automatic logic [7:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
      int p;
      p = int'($signed(a)) * int'($signed(b));
      return 8'(p);
   endfunction

   function automatic int ref_pick(input logic [3:0] mask, input int ptr);
      for (int k = 0; k < 4; k++)
         if (mask[(ptr + k) % 4]) return (ptr + k) % 4;
      return -1;
   endfunction

   // ---------------- drive helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int id, input logic [3:0] a, input logic [3:0] b);
      req_mcand[id*4 +: 4]  = a;
      req_mplier[id*4 +: 4] = b;
      req_valid[id]         = 1'b1;
   endtask

   task automatic apply_reset();
      reset_n    = 1'b0;
      req_valid  = '0;
      resp_ready = 1'b0;
      tick();
      tick();
      reset_n   = 1'b1;
      model_ptr = 0;
   endtask

   task automatic wait_grant(output logic ok);
      ok = 1'b0;
      #1;
      for (int c = 0; c < 100; c++) begin
         if (req_ready != 4'b0) begin
            ok = 1'b1;
            return;
         end
         tick();
      end
   endtask

   task automatic wait_resp(output logic ok);
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (resp_valid) begin
            ok = 1'b1;
            return;
         end
         tick();
      end
   endtask

   task automatic accept();
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
   endtask

   // One request from a lone requester, returning what came back.
   task automatic run_one(input int id, input logic [3:0] a, input logic [3:0] b,
                          output logic ok, output logic [7:0] prod,
                          output logic [1:0] rid, output logic err);
      logic okg, okr;
      set_req(id, a, b);
      wait_grant(okg);
      tick();
      req_valid[id] = 1'b0;
      model_ptr = (id + 1) % 4;
      wait_resp(okr);
      prod = resp_product;
      rid  = resp_id;
      err  = resp_error;
      accept();
      ok = okg & okr;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      req_valid = '0; req_mcand = '0; req_mplier = '0; resp_ready = 1'b0;
      stub_mode = 1'b0; stub_done = 1'b0; stub_prod = '0;
      reset_n = 1'b0;
      tick();
      checks++;
      if ({req_ready, resp_valid, resp_id, resp_product, resp_error, busy, mult_start,
           mult_mcand, mult_mplier, mult_abort} !== 27'b0) begin
         errors++;
         $display("FAIL reset_outputs got ready=%b rv=%b id=%0d prod=%h err=%b busy=%b st=%b ab=%b want all 0",
                  req_ready, resp_valid, resp_id, resp_product, resp_error, busy, mult_start, mult_abort);
      end
      tick();
      reset_n = 1'b1;
      model_ptr = 0;
   endtask

   task automatic test_single();
      logic ok;
      set_req(0, 4'hD, 4'h5);
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++; $display("FAIL single_ready got %b want 0001", req_ready);
      end
      tick();
      req_valid[0] = 1'b0;
      model_ptr = 1;
      checks++;
      if (mult_start !== 1'b1 || mult_mcand !== 4'hD || mult_mplier !== 4'h5 || busy !== 1'b1) begin
         errors++;
         $display("FAIL single_issue got start=%b mc=%h mp=%h busy=%b want 1 d 5 1",
                  mult_start, mult_mcand, mult_mplier, busy);
      end
      tick();
      checks++;
      if (mult_start !== 1'b0) begin
         errors++; $display("FAIL single_start_pulse got %b want 0", mult_start);
      end
      wait_resp(ok);
      checks++;
      if (!ok || resp_product !== 8'hF1 || resp_id !== 2'd0 || resp_error !== 1'b0) begin
         errors++;
         $display("FAIL single_resp got ok=%b prod=%h id=%0d err=%b want 1 f1 0 0",
                  ok, resp_product, resp_id, resp_error);
      end
      accept();
      checks++;
      if (resp_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL single_accept got rv=%b busy=%b want 0 0", resp_valid, busy);
      end
   endtask

   task automatic test_corners();
      logic [3:0] ta[3] = '{4'h8, 4'h7, 4'h0};
      logic [3:0] tb[3] = '{4'h8, 4'h8, 4'hF};
      logic [7:0] tp[3] = '{8'h40, 8'hC8, 8'h00};
      logic ok, err;
      logic [7:0] prod, expp;
      logic [1:0] rid;
      logic [3:0] a, b;
      int id;
      for (int i = 0; i < 11; i++) begin
         if (i < 3) begin
            id = i; a = ta[i]; b = tb[i]; expp = tp[i];
         end else begin
            id = int'($urandom_range(0, 3));
            a = 4'($urandom); b = 4'($urandom);
            expp = ref_mul(a, b);
         end
         run_one(id, a, b, ok, prod, rid, err);
         checks++;
         if (!ok || prod !== expp || rid !== 2'(id) || err !== 1'b0) begin
            errors++;
            $display("FAIL corner_%0d (%h*%h) got ok=%b prod=%h id=%0d err=%b want prod=%h id=%0d",
                     i, a, b, ok, prod, rid, err, expp, id);
         end
      end
   endtask

   task automatic test_round_robin();
      int exp_seq[5] = '{0, 1, 2, 3, 0};
      logic ok;
      int g;
      logic [3:0] a, b, m;
      apply_reset();
      for (int i = 0; i < 4; i++) set_req(i, 4'($urandom), 4'($urandom));
      for (int t = 0; t < 11; t++) begin
         if (t >= 5) begin
            m = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) begin
               if (m[i]) set_req(i, 4'($urandom), 4'($urandom));
               else req_valid[i] = 1'b0;
            end
         end
         wait_grant(ok);
         g = (t < 5) ? exp_seq[t] : ref_pick(req_valid, model_ptr);
         checks++;
         if (!ok || req_ready !== 4'(1 << g)) begin
            errors++; $display("FAIL rr_grant_%0d got %b want %b", t, req_ready, 4'(1 << g));
         end
         a = req_mcand[g*4 +: 4];
         b = req_mplier[g*4 +: 4];
         tick();
         model_ptr = (g + 1) % 4;
         set_req(g, 4'($urandom), 4'($urandom));
         wait_resp(ok);
         checks++;
         if (!ok || resp_id !== 2'(g) || resp_product !== ref_mul(a, b) || resp_error !== 1'b0) begin
            errors++;
            $display("FAIL rr_resp_%0d got ok=%b id=%0d prod=%h want id=%0d prod=%h",
                     t, ok, resp_id, resp_product, g, ref_mul(a, b));
         end
         accept();
      end
      req_valid = '0;
   endtask

   task automatic test_back_to_back();
      logic ok;
      int g;
      logic [3:0] a, b;
      resp_ready = 1'b1;
      for (int i = 0; i < 4; i++) set_req(i, 4'($urandom), 4'($urandom));
      for (int t = 0; t < 6; t++) begin
         wait_grant(ok);
         g = ref_pick(req_valid, model_ptr);
         checks++;
         if (!ok || req_ready !== 4'(1 << g)) begin
            errors++; $display("FAIL b2b_grant_%0d got %b want %b", t, req_ready, 4'(1 << g));
         end
         a = req_mcand[g*4 +: 4];
         b = req_mplier[g*4 +: 4];
         tick();
         model_ptr = (g + 1) % 4;
         if (t == 5) req_valid = '0;
         else set_req(g, 4'($urandom), 4'($urandom));
         wait_resp(ok);
         checks++;
         if (!ok || resp_id !== 2'(g) || resp_product !== ref_mul(a, b)) begin
            errors++;
            $display("FAIL b2b_resp_%0d got ok=%b id=%0d prod=%h want id=%0d prod=%h",
                     t, ok, resp_id, resp_product, g, ref_mul(a, b));
         end
         tick();
         checks++;
         if (resp_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_pulse_%0d resp_valid got %b want 0", t, resp_valid);
         end
      end
      resp_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      logic ok;
      logic [3:0] a, b;
      logic [7:0] hp;
      logic [1:0] hid;
      logic       herr;
      int g;
      a = 4'($urandom); b = 4'($urandom);
      set_req(1, a, b);
      wait_grant(ok);
      tick();
      req_valid[1] = 1'b0;
      model_ptr = 2;
      set_req(2, 4'($urandom), 4'($urandom));
      set_req(3, 4'($urandom), 4'($urandom));
      wait_resp(ok);
      hp = resp_product; hid = resp_id; herr = resp_error;
      checks++;
      if (!ok || hp !== ref_mul(a, b) || hid !== 2'd1 || herr !== 1'b0) begin
         errors++;
         $display("FAIL bp_resp got ok=%b prod=%h id=%0d err=%b want prod=%h id=1 err=0",
                  ok, hp, hid, herr, ref_mul(a, b));
      end
      for (int c = 0; c < 20; c++) begin
         tick();
         checks++;
         if (resp_valid !== 1'b1 || resp_product !== hp || resp_id !== hid || resp_error !== herr ||
             req_ready !== 4'b0 || mult_start !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold_%0d got rv=%b prod=%h id=%0d rdy=%b st=%b want rv=1 prod=%h id=%0d rdy=0 st=0",
                     c, resp_valid, resp_product, resp_id, req_ready, mult_start, hp, hid);
         end
      end
      accept();
      g = ref_pick(req_valid, model_ptr);
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 4'(1 << g)) begin
         errors++;
         $display("FAIL bp_next_grant got rv=%b rdy=%b want rv=0 rdy=%b", resp_valid, req_ready, 4'(1 << g));
      end
      a = req_mcand[g*4 +: 4];
      b = req_mplier[g*4 +: 4];
      tick();
      req_valid[g] = 1'b0;
      model_ptr = (g + 1) % 4;
      wait_resp(ok);
      checks++;
      if (!ok || resp_product !== ref_mul(a, b) || resp_id !== 2'(g)) begin
         errors++;
         $display("FAIL bp_second got ok=%b prod=%h id=%0d want prod=%h id=%0d",
                  ok, resp_product, resp_id, ref_mul(a, b), g);
      end
      // Requester 3 withdraws before it is granted.
      req_valid[3] = 1'b0;
      accept();
      tick();
      checks++;
      if (busy !== 1'b0 || req_ready !== 4'b0) begin
         errors++; $display("FAIL bp_withdraw got busy=%b rdy=%b want 0 0", busy, req_ready);
      end
   endtask

   task automatic test_watchdog();
      logic ok;
      int cnt;
      stub_mode = 1'b1; stub_done = 1'b0; stub_prod = 8'h00;
      set_req(3, 4'($urandom), 4'($urandom));
      wait_grant(ok);
      tick();
      req_valid[3] = 1'b0;
      model_ptr = 0;
      checks++;
      if (!ok || mult_start !== 1'b1) begin
         errors++; $display("FAIL wd_start got ok=%b start=%b want 1 1", ok, mult_start);
      end
      cnt = 0;
      while (mult_abort !== 1'b1 && cnt < 200) begin
         tick();
         cnt++;
      end
      checks++;
      if (cnt != TO) begin
         errors++; $display("FAIL wd_abort_time got %0d cycles want %0d", cnt, TO);
      end
      tick();
      checks++;
      if (mult_abort !== 1'b0 || resp_valid !== 1'b1 || resp_error !== 1'b1 ||
          resp_product !== 8'h00 || resp_id !== 2'd3) begin
         errors++;
         $display("FAIL wd_resp got ab=%b rv=%b err=%b prod=%h id=%0d want 0 1 1 00 3",
                  mult_abort, resp_valid, resp_error, resp_product, resp_id);
      end
      stub_done = 1'b1; stub_prod = 8'h55;
      tick();
      stub_done = 1'b0;
      checks++;
      if (resp_product !== 8'h00 || resp_error !== 1'b1 || resp_valid !== 1'b1) begin
         errors++;
         $display("FAIL wd_late_done got prod=%h err=%b rv=%b want 00 1 1", resp_product, resp_error, resp_valid);
      end
      accept();
      stub_done = 1'b1;
      tick();
      stub_done = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0 || resp_valid !== 1'b0) begin
         errors++; $display("FAIL wd_idle_done got busy=%b rv=%b want 0 0", busy, resp_valid);
      end
      // Done on the very cycle the watchdog expires must win.
      set_req(0, 4'($urandom), 4'($urandom));
      wait_grant(ok);
      tick();
      req_valid[0] = 1'b0;
      model_ptr = 1;
      for (int c = 1; c < TO; c++) tick();
      stub_done = 1'b1; stub_prod = 8'h7E;
      tick();
      stub_done = 1'b0;
      checks++;
      if (mult_abort !== 1'b0 || resp_valid !== 1'b1 || resp_error !== 1'b0 || resp_product !== 8'h7E) begin
         errors++;
         $display("FAIL wd_done_wins got ab=%b rv=%b err=%b prod=%h want 0 1 0 7e",
                  mult_abort, resp_valid, resp_error, resp_product);
      end
      accept();
      stub_mode = 1'b0;
   endtask

   task automatic test_reset_mid_wait();
      logic ok, err;
      logic [7:0] prod;
      logic [1:0] rid;
      set_req(1, 4'($urandom), 4'($urandom));
      wait_grant(ok);
      tick();
      req_valid[1] = 1'b0;
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({req_ready, resp_valid, resp_id, resp_product, resp_error, busy, mult_start,
           mult_mcand, mult_mplier, mult_abort} !== 27'b0) begin
         errors++;
         $display("FAIL midreset_outputs got busy=%b st=%b mc=%h mp=%h rv=%b want all 0",
                  busy, mult_start, mult_mcand, mult_mplier, resp_valid);
      end
      tick();
      tick();
      reset_n = 1'b1;
      model_ptr = 0;
      run_one(2, 4'h4, 4'hE, ok, prod, rid, err);
      checks++;
      if (!ok || prod !== 8'hF8 || rid !== 2'd2 || err !== 1'b0) begin
         errors++;
         $display("FAIL midreset_after got ok=%b prod=%h id=%0d err=%b want f8 2 0", ok, prod, rid, err);
      end
   endtask

   initial begin
      #600000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      test_reset();
      test_single();
      test_corners();
      test_round_robin();
      test_back_to_back();
      test_backpressure();
      test_watchdog();
      test_reset_mid_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
